c_mac_seq: RTL and testbench



---
 rtl/c_mac_seq.sv | 260 ++++++++++++++++++++++++++
 tb/tb_c_mac_seq.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c_mac_seq.sv
// -----------------------------------------------------------------------------
// c_mac_seq
//
// Operand sequencer and result collector for the complex MAC (c_mac).
// Accepts a valid/ready stream of complex operand pairs and forms each group
// of TERMS accepted pairs into one dot product. The MAC sees a one-cycle
// mac_clear, then the registered operand beats with mac_en, and then the
// sequencer waits for the MAC to drain. The MAC's result is captured into a
// small FIFO that presents results downstream over valid/ready.
//
// A group only starts when the FIFO has a free slot, so a push can never
// land on a full FIFO. Because a new mac_clear requires passing through
// DRAIN, IDLE and CLEAR, the MAC pipeline is always empty when it is cleared.
// The MAC must share rst_n so that a reset mid-group leaves no stale product.
//
// Optional feature (macro C_MAC_SEQ_TIMEOUT_EN):
//   defined   - a drain watchdog counts DRAIN cycles. If no mac_result_valid
//               has arrived after LATENCY+2 cycles, err_timeout is set
//               (sticky until reset), the group is dropped without a push and
//               the FSM returns to IDLE.
//   undefined - DRAIN waits indefinitely; err_timeout is tied to 0.
//
// Parameters:
//   N       operand / result word width
//   Q       fraction bits (informational; no arithmetic is done here)
//   TERMS   pairs per group, must match the MAC's term count
//   LATENCY MAC cycles from mac_en to mac_result_valid
//   DEPTH   result FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             operand pair handshake
//   in_ar, in_ai, in_br, in_bi      signed operands a, b
//   mac_clear                       MAC accumulator/counter clear pulse
//   mac_en                          MAC operand valid
//   mac_ar, mac_ai, mac_br, mac_bi  registered operands to the MAC
//   mac_r_out, mac_i_out            MAC result
//   mac_result_valid                MAC result valid
//   out_valid / out_ready           result handshake (FIFO head)
//   out_r, out_i                    FIFO head result (0 when empty)
//   fifo_count                      FIFO occupancy
//   err_timeout                     sticky drain-timeout flag
// -----------------------------------------------------------------------------
module c_mac_seq #(
    parameter int N       = 16,
    parameter int Q       = 8,
    parameter int TERMS   = 4,
    parameter int LATENCY = 6,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_ar,
    input  logic [N-1:0]               in_ai,
    input  logic [N-1:0]               in_br,
    input  logic [N-1:0]               in_bi,
    output logic                       mac_clear,
    output logic                       mac_en,
    output logic [N-1:0]               mac_ar,
    output logic [N-1:0]               mac_ai,
    output logic [N-1:0]               mac_br,
    output logic [N-1:0]               mac_bi,
    input  logic [N-1:0]               mac_r_out,
    input  logic [N-1:0]               mac_i_out,
    input  logic                       mac_result_valid,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_r,
    output logic [N-1:0]               out_i,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       err_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (TERMS > 1) ? $clog2(TERMS) : 1;

    // Elaboration-time sanity check of the parameter set.
    if (TERMS < 1 || LATENCY < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0
        || Q < 0 || Q >= N) begin : g_param_check
        $error("c_mac_seq: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [BW-1:0]   beat_cnt;
    logic            last_beat;
    logic            accept;
    logic            push;
    logic            pop;
    logic            timeout;

    logic [N-1:0]    mem_r [DEPTH];
    logic [N-1:0]    mem_i [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    assign accept    = in_valid & in_ready;
    assign last_beat = (beat_cnt == BW'(TERMS - 1));

    // -------------------------------------------------------------------------
    // Drain watchdog
    // -------------------------------------------------------------------------
`ifdef C_MAC_SEQ_TIMEOUT_EN
    localparam int DW = $clog2(LATENCY + 2) + 1;

    logic [DW-1:0] drain_cnt;
    logic          err_q;

    // drain_cnt holds the number of DRAIN cycles already spent; a result that
    // arrives in the last allowed cycle still wins over the timeout.
    assign timeout = (state == S_DRAIN) && !mac_result_valid
                     && (drain_cnt == DW'(LATENCY + 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    // NOTE: state elements use non-blocking (<=) so every flop samples the
    // pre-edge values of the others; blocking here would create order races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        mac_clear = 1'b0;
        push      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (in_valid && (count < CW'(DEPTH))) begin
                    state_nx = S_CLEAR;
                end
            end
            S_CLEAR: begin
                mac_clear = 1'b1;
                state_nx  = S_ISSUE;
            end
            S_ISSUE: begin
                in_ready = 1'b1;
                // in_ready is 1 here, so in_valid alone marks an accept.
                if (in_valid && last_beat) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mac_result_valid) begin
                    push     = 1'b1;
                    state_nx = S_IDLE;
                end else if (timeout) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Beat counter and registered MAC operands
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            mac_en   <= 1'b0;
            mac_ar   <= '0;
            mac_ai   <= '0;
            mac_br   <= '0;
            mac_bi   <= '0;
        end else begin
            mac_en <= accept;
            if (state == S_CLEAR) begin
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (accept) begin
                mac_ar <= in_ar;
                mac_ai <= in_ai;
                mac_br <= in_br;
                mac_bi <= in_bi;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result FIFO
    // -------------------------------------------------------------------------
    assign out_valid  = (count != '0);
    assign pop        = out_valid & out_ready;
    assign fifo_count = count;
    // The head is masked while empty so the outputs read 0 after reset even
    // though the storage itself is never cleared.
    assign out_r      = out_valid ? mem_r[rd_ptr] : '0;
    assign out_i      = out_valid ? mem_i[rd_ptr] : '0;

    // NOTE: the storage array has no reset; validity is tracked by count and
    // the pointers, so clearing the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr] <= mac_r_out;
            mem_i[wr_ptr] <= mac_i_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_c_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_c_mac_seq
//
// Self-checking bench for c_mac_seq. A behavioural complex MAC (TERMS terms,
// LATENCY cycles, products scaled by 2^-Q) sits on the MAC side. Groups come
// from a table of operand sets with hand-computed dot products; hand-written
// sequences cover bubbles, stray MAC results, backpressure, the drain timeout
// and a mid-group reset.
// -----------------------------------------------------------------------------
module tb_c_mac_seq;

    localparam int N       = 16;
    localparam int Q       = 8;
    localparam int TERMS   = 4;
    localparam int LATENCY = 6;
    localparam int DEPTH   = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid;
    logic                   in_ready;
    logic [N-1:0]           in_ar, in_ai, in_br, in_bi;
    logic                   mac_clear;
    logic                   mac_en;
    logic [N-1:0]           mac_ar, mac_ai, mac_br, mac_bi;
    logic [N-1:0]           mac_r_out, mac_i_out;
    logic                   mac_result_valid;
    logic                   out_valid;
    logic                   out_ready;
    logic [N-1:0]           out_r, out_i;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   err_timeout;

    c_mac_seq #(
        .N(N), .Q(Q), .TERMS(TERMS), .LATENCY(LATENCY), .DEPTH(DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_ar            (in_ar),
        .in_ai            (in_ai),
        .in_br            (in_br),
        .in_bi            (in_bi),
        .mac_clear        (mac_clear),
        .mac_en           (mac_en),
        .mac_ar           (mac_ar),
        .mac_ai           (mac_ai),
        .mac_br           (mac_br),
        .mac_bi           (mac_bi),
        .mac_r_out        (mac_r_out),
        .mac_i_out        (mac_i_out),
        .mac_result_valid (mac_result_valid),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_r            (out_r),
        .out_i            (out_i),
        .fifo_count       (fifo_count),
        .err_timeout      (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural MAC: accumulate scaled complex products, emit the sum
    // LATENCY cycles after the mac_en of the last term.
    // -------------------------------------------------------------------------
    bit                mac_dead = 1'b0;  // swallow results (timeout test)
    bit                stray_v  = 1'b0;  // inject a result outside DRAIN
    logic [LATENCY-1:0] pipe_v;
    logic [N-1:0]      pipe_r [LATENCY];
    logic [N-1:0]      pipe_i [LATENCY];
    int                acc_r, acc_i, terms;

    always @(posedge clk or negedge rst_n) begin : mac_model
        int nr, ni, nt;
        if (!rst_n) begin
            pipe_v <= '0;
            acc_r  <= 0;
            acc_i  <= 0;
            terms  <= 0;
            for (int k = 0; k < LATENCY; k++) begin
                pipe_r[k] <= '0;
                pipe_i[k] <= '0;
            end
        end else begin
            nr = acc_r;
            ni = acc_i;
            nt = terms;
            if (mac_clear) begin
                nr = 0;
                ni = 0;
                nt = 0;
            end
            if (mac_en) begin
                nr += (int'($signed(mac_ar)) * int'($signed(mac_br))
                     - int'($signed(mac_ai)) * int'($signed(mac_bi))) >>> Q;
                ni += (int'($signed(mac_ar)) * int'($signed(mac_bi))
                     + int'($signed(mac_ai)) * int'($signed(mac_br))) >>> Q;
                nt++;
            end
            pipe_v <= {pipe_v[LATENCY-2:0], 1'b0};
            for (int k = LATENCY - 1; k > 0; k--) begin
                pipe_r[k] <= pipe_r[k-1];
                pipe_i[k] <= pipe_i[k-1];
            end
            if (nt == TERMS) begin
                pipe_v[0] <= !mac_dead;
                pipe_r[0] <= nr[N-1:0];
                pipe_i[0] <= ni[N-1:0];
                nr = 0;
                ni = 0;
                nt = 0;
            end
            acc_r <= nr;
            acc_i <= ni;
            terms <= nt;
        end
    end

    assign mac_result_valid = pipe_v[LATENCY-1] | stray_v;
    assign mac_r_out        = stray_v ? 16'h7777 : pipe_r[LATENCY-1];
    assign mac_i_out        = stray_v ? 16'h5555 : pipe_i[LATENCY-1];

    // -------------------------------------------------------------------------
    // Monitor: count MAC pulses; a clear must never follow an en by LATENCY
    // cycles or less.
    // -------------------------------------------------------------------------
    int en_cnt = 0;
    int clr_cnt = 0;
    int last_en_cyc = -1000;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_en_cyc = -1000;
        end else begin
            if (mac_en) begin
                en_cnt++;
                last_en_cyc = cyc;
            end
            if (mac_clear) begin
                clr_cnt++;
                check("clear_vs_inflight", 32'(cyc - last_en_cyc > LATENCY), 1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Vector table
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [TERMS-1:0][N-1:0] ar, ai, br, bi;
        logic [N-1:0]            er, ei;
    } vec_t;

    vec_t vecs [4];

    task automatic run_group(input int idx, input bit bubbles, input int nbeats,
                             output int c0);
        int beat = 0;
        bit hole = 1'b0;
        int budget = 0;
        c0 = -1;
        while (beat < nbeats && budget < 200) begin
            if (bubbles && hole) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_ar = vecs[idx].ar[beat];
                in_ai = vecs[idx].ai[beat];
                in_br = vecs[idx].br[beat];
                in_bi = vecs[idx].bi[beat];
            end
            hole = !hole;
            if (in_valid && in_ready) begin
                beat++;
                c0 = cyc;
            end
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0;
        check("beats_accepted", beat, nbeats);
        if (beat == nbeats) check("mac_en_after_last_beat", 32'(mac_en), 1);
    endtask

    task automatic wait_result(input int c0, input int prev, input int en0);
        int budget = 0;
        while (cyc < c0 + 7 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("fifo_count_at_c0+7", fifo_count, prev);
        @(negedge clk);
        check("fifo_count_at_c0+8", fifo_count, prev + 1);
        check("out_valid_at_c0+8", 32'(out_valid), 1);
        check("mac_en_pulses", en_cnt - en0, TERMS);
    endtask

    task automatic pop_check(input int idx);
        check("pop_out_valid", 32'(out_valid), 1);
        check("pop_out_r", out_r, vecs[idx].er);
        check("pop_out_i", out_i, vecs[idx].ei);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mac_clear", 32'(mac_clear), 0);
        check("rst_mac_en", 32'(mac_en), 0);
        check("rst_mac_ar", mac_ar, 0);
        check("rst_mac_ai", mac_ai, 0);
        check("rst_mac_br", mac_br, 0);
        check("rst_mac_bi", mac_bi, 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_r", out_r, 0);
        check("rst_out_i", out_i, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_err_timeout", 32'(err_timeout), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int c0, en0, clr0, budget;

        // 1.0 * 1.0 four times -> 4.0 = 1024 + 0j
        vecs[0].ar = {16'd256, 16'd256, 16'd256, 16'd256};
        vecs[0].ai = '0;
        vecs[0].br = {16'd256, 16'd256, 16'd256, 16'd256};
        vecs[0].bi = '0;
        vecs[0].er = 16'd1024;
        vecs[0].ei = 16'd0;
        // (1+j)(1-j) = 2 per term -> 8.0 = 2048 + 0j
        vecs[1].ar = {16'd256, 16'd256, 16'd256, 16'd256};
        vecs[1].ai = {16'd256, 16'd256, 16'd256, 16'd256};
        vecs[1].br = {16'd256, 16'd256, 16'd256, 16'd256};
        vecs[1].bi = {16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
        vecs[1].er = 16'd2048;
        vecs[1].ei = 16'd0;
        // j * j = -1 per term -> -4.0 = -1024 + 0j
        vecs[2].ar = '0;
        vecs[2].ai = {16'd256, 16'd256, 16'd256, 16'd256};
        vecs[2].br = '0;
        vecs[2].bi = {16'd256, 16'd256, 16'd256, 16'd256};
        vecs[2].er = 16'hFC00;
        vecs[2].ei = 16'd0;
        // 2*0.5 + j*1 + (-1)*1 + (1.5+0.5j)*1 = 1.5 + 1.5j = 384 + 384j
        vecs[3].ar = {16'd512, 16'd0,   16'hFF00, 16'd384};
        vecs[3].ai = {16'd0,   16'd256, 16'd0,    16'd128};
        vecs[3].br = {16'd128, 16'd256, 16'd256,  16'd256};
        vecs[3].bi = '0;
        vecs[3].er = 16'd384;
        vecs[3].ei = 16'd384;

        // ---- Reset with random inputs ----
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            in_ar     = N'($urandom);
            in_ai     = N'($urandom);
            in_br     = N'($urandom);
            in_bi     = N'($urandom);
            out_ready = 1'($urandom);
            stray_v   = 1'($urandom);
        end
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        stray_v = 1'b0;
        repeat (5) @(negedge clk);
        check("no_clear_without_valid", clr_cnt, 0);
        check("idle_in_ready", 32'(in_ready), 0);

        // ---- Table-driven groups ----
        for (int i = 0; i < 4; i++) begin
            en0 = en_cnt;
            run_group(i, 1'b0, TERMS, c0);
            wait_result(c0, 0, en0);
            pop_check(i);
            check("fifo_empty_after_pop", fifo_count, 0);
        end

        // ---- Bubbles ----
        en0 = en_cnt;
        run_group(0, 1'b1, TERMS, c0);
        wait_result(c0, 0, en0);
        pop_check(0);

        // ---- Stray MAC result outside DRAIN is ignored ----
        stray_v = 1'b1;
        @(negedge clk);
        stray_v = 1'b0;
        @(negedge clk);
        check("stray_fifo_count", fifo_count, 0);
        check("stray_out_valid", 32'(out_valid), 0);

        // ---- Backpressure: fill FIFO, hold group 5 in IDLE ----
        for (int g = 0; g < DEPTH; g++) begin
            en0 = en_cnt;
            run_group(g, 1'b0, TERMS, c0);
            wait_result(c0, g, en0);
        end
        clr0 = clr_cnt;
        in_valid = 1'b1;
        in_ar = vecs[0].ar[0];
        in_ai = vecs[0].ai[0];
        in_br = vecs[0].br[0];
        in_bi = vecs[0].bi[0];
        repeat (20) @(negedge clk);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_fifo_count", fifo_count, DEPTH);
        check("full_no_clear", clr_cnt - clr0, 0);
        pop_check(0);
        en0 = en_cnt;
        run_group(0, 1'b0, TERMS, c0);
        wait_result(c0, DEPTH - 1, en0);
        pop_check(1);
        pop_check(2);
        pop_check(3);
        pop_check(0);
        check("drained_fifo_count", fifo_count, 0);

        // ---- Drain timeout ----
        mac_dead = 1'b1;
        clr0 = clr_cnt;
        en0 = en_cnt;
        run_group(2, 1'b0, TERMS, c0);
`ifdef C_MAC_SEQ_TIMEOUT_EN
        budget = 0;
        while (cyc < c0 + 8 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("timeout_not_yet", 32'(err_timeout), 0);
        @(negedge clk);
        check("timeout_set", 32'(err_timeout), 1);
        check("timeout_no_push", fifo_count, 0);
        mac_dead = 1'b0;
        en0 = en_cnt;
        run_group(1, 1'b0, TERMS, c0);
        wait_result(c0, 0, en0);
        pop_check(1);
        check("timeout_sticky", 32'(err_timeout), 1);
`else
        budget = 0;
        in_valid = 1'b1;
        repeat (30) @(negedge clk);
        check("drain_hold_in_ready", 32'(in_ready), 0);
        check("drain_hold_err", 32'(err_timeout), 0);
        check("drain_hold_fifo", fifo_count, 0);
        check("drain_hold_one_clear", clr_cnt - clr0, 1);
        in_valid = 1'b0;
        mac_dead = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        // ---- Mid-group reset ----
        run_group(1, 1'b0, 2, c0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_mac_en", 32'(mac_en), 0);
        check("post_rst_fifo", fifo_count, 0);
        en0 = en_cnt;
        run_group(3, 1'b0, TERMS, c0);
        wait_result(c0, 0, en0);
        pop_check(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
